regfl_rd: RTL and testbench
===========================

Name: regfl_rd

Overview:
Read-side controller for the 8x64 register file. It takes the file's flattened 512-bit state bus and accepts burst read requests over a valid/ready handshake. It then streams the selected registers out one word per beat through a registered, backpressurable output stage. It sits between the register file and any consumer (debug dump, datapath operand fetch) that reads the file.

Parameters:
W, 64, register width in bits
N, 8, number of registers (power of two)
AW, 3, address width, log2(N)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
q  in  N*W  flattened register file state; register i occupies q[N*W-1-i*W -: W] (reg 0 at MSBs)
req_valid  in  1  burst request present
req_ready  out  1  request can be accepted
req_addr  in  AW  first register index
req_len  in  AW  beats minus one (0 = 1 word, N-1 = whole file)
rd_valid  out  1  output beat valid
rd_ready  in  1  consumer accepts beat
rd_data  out  W  register contents
rd_addr  out  AW  index of the register in rd_data
rd_last  out  1  final beat of the burst
busy  out  1  state is BURST or a beat is pending

Behaviour:
- Reset (async, rst=1): state IDLE, rd_valid=0, rd_data=0, rd_addr=0, rd_last=0, ptr=0, remaining=0. Outputs return to these values immediately; any burst in progress is dropped with no partial beat.
- States: IDLE, BURST.
- req_ready = (state==IDLE). A request is accepted on an edge with req_valid & req_ready. On acceptance: ptr<=req_addr, remaining<=req_len, state<=BURST.
- Output stage is free when (!rd_valid | rd_ready).
- In BURST on each edge with the output stage free:
  - rd_data<=word[ptr], rd_addr<=ptr, rd_last<=(remaining==0), rd_valid<=1.
  - ptr<=ptr+1 mod N (wraps 7->0).
  - remaining<=remaining-1.
  - If remaining==0, state<=IDLE.
- In BURST with the stage not free: hold everything.
- If a beat is consumed with no new load, rd_valid<=0.
- Latency: request accepted at edge T; first beat valid after edge T+1. With rd_ready held high, one beat per cycle, so a burst of L+1 words occupies edges T+1..T+1+L.
- Backpressure: while rd_valid & !rd_ready, rd_data/rd_addr/rd_last are stable. The snapshot is taken at load time, not at consume time.
- A register written in the same edge as its load yields the pre-write value.
- A new request can be accepted in IDLE while the last beat is still pending. Its first load waits for the output stage to be free.
- req_len=N-1 starting at addr a reads all N registers, wrapping, ending at a-1.
- busy = (state==BURST) | rd_valid.

Optional Feature:
Macro REGFL_RD_PARITY_EN.
- Defined: adds output rd_par (1 bit), registered with rd_data, equal to the even parity (XOR reduction) of the loaded word. Reset value 0.
- Undefined: port absent; no parity logic.

Decomposition:
- Shared package regfl_pkg holds:
  - constants REGFL_W=64, REGFL_N=8, REGFL_AW=3;
  - state enum (IDLE=1'b0, BURST=1'b1).
- One sub-module: regfl_mux, a combinational N:1 W-bit word selector from the flattened bus, indexed by ptr. The FSM and output registers stay in regfl_rd.

Test Plan:
- Reset mid-burst: assert rst during beat 2 of a len=7 burst -> rd_valid=0, req_ready=1 in the same cycle; a later request starts cleanly.
- Single read: reg 5 = 64'hDEAD_BEEF_0123_4567, req addr=5 len=0 at edge T -> after T+1, rd_valid=1, rd_data=64'hDEAD_BEEF_0123_4567, rd_addr=5, rd_last=1; busy low after the consume.
- Wrap burst: reg i = i*64'h1111, req addr=6 len=3, rd_ready=1 -> beats addr 6,7,0,1 with data 6666,7777,0,1111 on consecutive cycles; rd_last only on addr 1.
- Backpressure: full dump addr=0 len=7, rd_ready low for 3 cycles after beat 2 -> rd_data/rd_addr frozen at addr 2; all 8 beats delivered in order, none duplicated or lost.
- Write/read collision: the register file writes reg 3 on the same edge regfl_rd loads addr 3 -> old value returned. A back-to-back request accepted while the last beat stalls -> its first beat follows immediately after the consume.

Source files
------------

// File: rtl/regfl_pkg.sv
// regfl_pkg: shared register-file geometry constants and read-controller state encoding
package regfl_pkg;
  localparam int REGFL_W = 64;
  localparam int REGFL_N = 8;
  localparam int REGFL_AW = 3;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
endpackage

// File: rtl/regfl_rd_if.sv
// regfl_rd_if: burst request and read-beat stream bundle; rd_par exists only with REGFL_RD_PARITY_EN
interface regfl_rd_if;
  import regfl_pkg::*;
  logic req_valid;
  logic req_ready;
  logic [REGFL_AW-1:0] req_addr;
  logic [REGFL_AW-1:0] req_len;
  logic rd_valid;
  logic rd_ready;
  logic [REGFL_W-1:0] rd_data;
  logic [REGFL_AW-1:0] rd_addr;
  logic rd_last;
  logic busy;
`ifdef REGFL_RD_PARITY_EN
  logic rd_par;
  modport slave (input req_valid, req_addr, req_len, rd_ready, output req_ready, rd_valid, rd_data, rd_addr, rd_last, busy, rd_par);
  modport master (output req_valid, req_addr, req_len, rd_ready, input req_ready, rd_valid, rd_data, rd_addr, rd_last, busy, rd_par);
`else
  modport slave (input req_valid, req_addr, req_len, rd_ready, output req_ready, rd_valid, rd_data, rd_addr, rd_last, busy);
  modport master (output req_valid, req_addr, req_len, rd_ready, input req_ready, rd_valid, rd_data, rd_addr, rd_last, busy);
`endif
endinterface

// File: rtl/regfl_mux.sv
// regfl_mux: combinational N:1 word selector from the flattened register bus (reg 0 at MSBs)
module regfl_mux import regfl_pkg::*; #(
  parameter int W = REGFL_W,
  parameter int N = REGFL_N,
  parameter int AW = REGFL_AW
) (
  input  logic [N*W-1:0] q,
  input  logic [AW-1:0]  sel,
  output logic [W-1:0]   word
);
  assign word = q[(N-1-int'(sel))*W +: W];
endmodule

// File: rtl/regfl_rd.sv
// regfl_rd: burst read controller streaming register-file words through a registered backpressurable stage; REGFL_RD_PARITY_EN adds rd_par
module regfl_rd import regfl_pkg::*; (
  input logic clk,
  input logic rst,
  input logic [REGFL_N*REGFL_W-1:0] q,
  regfl_rd_if.slave bus
);
  state_t state, state_n;
  logic [REGFL_AW-1:0] ptr, remaining;
  logic [REGFL_W-1:0] word;
  logic free, accept, load;
  regfl_mux u_mux (.q(q), .sel(ptr), .word(word));
  assign free = !bus.rd_valid | bus.rd_ready;
  assign accept = (state == IDLE) & bus.req_valid;
  assign load = (state == BURST) & free;
  assign bus.req_ready = (state == IDLE);
  assign bus.busy = (state == BURST) | bus.rd_valid;
  // next state: enter BURST on accept, leave after loading the final beat
  always_comb begin
    state_n = accept ? BURST : (load && remaining == '0) ? IDLE : state;
  end
  // state, read pointer and beats-remaining counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      remaining <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        ptr <= bus.req_addr;
        remaining <= bus.req_len;
      end else if (load) begin
        ptr <= ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  // output stage snapshots the word at load time and holds it under backpressure
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data <= '0;
      bus.rd_addr <= '0;
      bus.rd_last <= 1'b0;
`ifdef REGFL_RD_PARITY_EN
      bus.rd_par <= 1'b0;
`endif
    end else if (load) begin
      bus.rd_valid <= 1'b1;
      bus.rd_data <= word;
      bus.rd_addr <= ptr;
      bus.rd_last <= (remaining == '0);
`ifdef REGFL_RD_PARITY_EN
      bus.rd_par <= ^word;
`endif
    end else if (bus.rd_ready) begin
      bus.rd_valid <= 1'b0;
    end
endmodule

// File: tb/tb_regfl_rd.sv
// tb_regfl_rd: directed self-checking bench for regfl_rd
module tb_regfl_rd;
  import regfl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [REGFL_N*REGFL_W-1:0] q;
  logic [63:0] regs [8];
  logic wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  int total = 0;
  int bad = 0;
  regfl_rd_if bus();
  regfl_rd dut (.clk(clk), .rst(rst), .q(q), .bus(bus));
  always #5 clk = ~clk;
  always_comb begin
    q = '0;
    for (int i = 0; i < 8; i++) q[511-i*64 -: 64] = regs[i];
  end
  always @(posedge clk) if (wr_en) regs[wr_addr] <= wr_data;

  task automatic test_reset;
    @(negedge clk);
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", bus.rd_valid); end
    total++; if (bus.rd_data !== 64'h0) begin bad++; $display("FAIL reset_data got %h want 0", bus.rd_data); end
    total++; if (bus.rd_addr !== 3'd0 || bus.rd_last !== 1'b0) begin bad++; $display("FAIL reset_addr_last got %0d/%b want 0/0", bus.rd_addr, bus.rd_last); end
    total++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL reset_ready_busy got %b/%b want 1/0", bus.req_ready, bus.busy); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    regs[5] = 64'hDEAD_BEEF_0123_4567;
    bus.req_valid = 1'b1; bus.req_addr = 3'd5; bus.req_len = 3'd0; bus.rd_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    total++; if (bus.req_ready !== 1'b0 || bus.rd_valid !== 1'b0) begin bad++; $display("FAIL single_t got ready=%b valid=%b want 0/0", bus.req_ready, bus.rd_valid); end
    @(negedge clk);
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_last !== 1'b1) begin bad++; $display("FAIL single_valid_last got %b/%b want 1/1", bus.rd_valid, bus.rd_last); end
    total++; if (bus.rd_data !== 64'hDEAD_BEEF_0123_4567) begin bad++; $display("FAIL single_data got %h want deadbeef01234567", bus.rd_data); end
    total++; if (bus.rd_addr !== 3'd5) begin bad++; $display("FAIL single_addr got %0d want 5", bus.rd_addr); end
`ifdef REGFL_RD_PARITY_EN
    total++; if (bus.rd_par !== 1'b0) begin bad++; $display("FAIL single_par got %b want 0", bus.rd_par); end
`endif
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy_pending got %b want 1", bus.busy); end
    bus.rd_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL single_after got valid=%b busy=%b want 0/0", bus.rd_valid, bus.busy); end
  endtask

  task automatic test_wrap;
    logic [2:0] ea [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
    logic [63:0] ed [4] = '{64'h6666, 64'h7777, 64'h0, 64'h1111};
    for (int i = 0; i < 8; i++) regs[i] = 64'(i) * 64'h1111;
    bus.req_valid = 1'b1; bus.req_addr = 3'd6; bus.req_len = 3'd3; bus.rd_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (bus.rd_valid !== 1'b1 || bus.rd_addr !== ea[k]) begin bad++; $display("FAIL wrap_addr%0d got v=%b a=%0d want 1/%0d", k, bus.rd_valid, bus.rd_addr, ea[k]); end
      total++; if (bus.rd_data !== ed[k]) begin bad++; $display("FAIL wrap_data%0d got %h want %h", k, bus.rd_data, ed[k]); end
      total++; if (bus.rd_last !== (k == 3)) begin bad++; $display("FAIL wrap_last%0d got %b want %b", k, bus.rd_last, k == 3); end
    end
    @(negedge clk);
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL wrap_end got %b want 0", bus.rd_valid); end
  endtask

  task automatic test_backpressure;
    int exp_a = 0;
    int stall = 0;
    for (int i = 0; i < 8; i++) regs[i] = 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h0101;
    bus.req_valid = 1'b1; bus.req_addr = 3'd0; bus.req_len = 3'd7; bus.rd_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int c = 0; c < 30 && exp_a < 8; c++) begin
      @(negedge clk);
      if (bus.rd_valid && bus.rd_addr == 3'd2 && stall < 3) begin
        bus.rd_ready = 1'b0;
        if (stall > 0) begin
          total++; if (bus.rd_data !== 64'hA5A5_0000_0000_0202) begin bad++; $display("FAIL bp_frozen%0d got a=%0d d=%h want 2/a5a5000000000202", stall, bus.rd_addr, bus.rd_data); end
        end
        stall++;
      end else bus.rd_ready = 1'b1;
      if (bus.rd_valid && bus.rd_ready) begin
        total++; if (bus.rd_addr !== 3'(exp_a) || bus.rd_data !== 64'hA5A5_0000_0000_0000 + 64'(exp_a) * 64'h0101) begin bad++; $display("FAIL bp_beat%0d got a=%0d d=%h", exp_a, bus.rd_addr, bus.rd_data); end
        total++; if (bus.rd_last !== (exp_a == 7)) begin bad++; $display("FAIL bp_last%0d got %b want %b", exp_a, bus.rd_last, exp_a == 7); end
        exp_a++;
      end
    end
    total++; if (exp_a !== 8 || stall !== 3) begin bad++; $display("FAIL bp_count got beats=%0d stalls=%0d want 8/3", exp_a, stall); end
    bus.rd_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL bp_end got %b want 0", bus.rd_valid); end
  endtask

  task automatic test_collision;
    regs[3] = 64'h0000_0000_0000_0AAA;
    regs[4] = 64'h0000_0000_0000_0444;
    bus.req_valid = 1'b1; bus.req_addr = 3'd3; bus.req_len = 3'd0; bus.rd_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 64'h0000_0000_0000_0BBB;
    @(negedge clk);
    wr_en = 1'b0;
    total++; if (bus.rd_data !== 64'h0AAA || bus.rd_addr !== 3'd3) begin bad++; $display("FAIL coll_old got a=%0d d=%h want 3/aaa", bus.rd_addr, bus.rd_data); end
    total++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_ready got %b/%b want 1/1", bus.req_ready, bus.busy); end
    bus.req_valid = 1'b1; bus.req_addr = 3'd3; bus.req_len = 3'd1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 64'h0AAA || bus.rd_last !== 1'b1) begin bad++; $display("FAIL b2b_hold got v=%b d=%h l=%b want 1/aaa/1", bus.rd_valid, bus.rd_data, bus.rd_last); end
    bus.rd_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_addr !== 3'd3 || bus.rd_data !== 64'h0BBB || bus.rd_last !== 1'b0) begin bad++; $display("FAIL b2b_first got v=%b a=%0d d=%h l=%b want 1/3/bbb/0", bus.rd_valid, bus.rd_addr, bus.rd_data, bus.rd_last); end
    @(negedge clk);
    total++; if (bus.rd_addr !== 3'd4 || bus.rd_data !== 64'h0444 || bus.rd_last !== 1'b1) begin bad++; $display("FAIL b2b_second got a=%0d d=%h l=%b want 4/444/1", bus.rd_addr, bus.rd_data, bus.rd_last); end
    @(negedge clk);
    total++; if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_end got %b/%b want 0/0", bus.rd_valid, bus.busy); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 8; i++) regs[i] = 64'(i) * 64'h1111;
    bus.req_valid = 1'b1; bus.req_addr = 3'd0; bus.req_len = 3'd7; bus.rd_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_addr !== 3'd2) begin bad++; $display("FAIL mid_beat2 got v=%b a=%0d want 1/2", bus.rd_valid, bus.rd_addr); end
    rst = 1'b1;
    #1;
    total++; if (bus.rd_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL mid_reset got v=%b r=%b b=%b want 0/1/0", bus.rd_valid, bus.req_ready, bus.busy); end
    total++; if (bus.rd_data !== 64'h0 || bus.rd_addr !== 3'd0) begin bad++; $display("FAIL mid_reset_regs got a=%0d d=%h want 0/0", bus.rd_addr, bus.rd_data); end
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b1; bus.req_addr = 3'd4; bus.req_len = 3'd0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_addr !== 3'd4 || bus.rd_data !== 64'h4444 || bus.rd_last !== 1'b1) begin bad++; $display("FAIL mid_restart got v=%b a=%0d d=%h l=%b want 1/4/4444/1", bus.rd_valid, bus.rd_addr, bus.rd_data, bus.rd_last); end
    @(negedge clk);
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL mid_restart_end got %b want 0", bus.rd_valid); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = '0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_len = '0; bus.rd_ready = 1'b0;
    test_reset;
    test_single;
    test_wrap;
    test_backpressure;
    test_collision;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
